// File: rtl/wormhole_arbiter_if.sv
// wormhole_arbiter_if: request/grant bundle between input buffers and the wormhole output-port arbiter
//   master: req, head, hdr_fmt, hdr_len, credit_avail out; grant, owner, xfer, tail, busy in
//   slave : the arbiter side, directions reversed
interface wormhole_arbiter_if #(
  parameter int NUM_REQ = 5,
  parameter int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] head;
  logic [NUM_REQ-1:0][3:0] hdr_fmt;
  logic [NUM_REQ-1:0][6:0] hdr_len;
  logic credit_avail;
  logic [NUM_REQ-1:0] grant;
  logic [OW-1:0] owner;
  logic xfer;
  logic tail;
  logic busy;
  modport master (
    output req, head, hdr_fmt, hdr_len, credit_avail,
    input grant, owner, xfer, tail, busy
  );
  modport slave (
    input req, head, hdr_fmt, hdr_len, credit_avail,
    output grant, owner, xfer, tail, busy
  );
endinterface

// File: rtl/wormhole_arbiter.sv
// wormhole_arbiter: round-robin output-port arbiter that locks the port to one buffer for a whole packet
//   clk, rst (async, active-high); bus (slave): req/head/hdr_fmt/hdr_len/credit_avail in,
//   grant/owner/xfer/tail/busy out. Header fmt codes: 0 short read, 1 short write,
//   2 long read, 3 long write. Define WH_ARB_FAST_HANDOFF_EN to re-arbitrate on the tail
//   cycle so the next packet starts with no idle bubble.
module wormhole_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int CNT_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  wormhole_arbiter_if.slave bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] FMT_SHORT_READ = 4'h0;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'h1;
  localparam logic [3:0] FMT_LONG_READ = 4'h2;
  localparam logic [3:0] FMT_LONG_WRITE = 4'h3;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, elig;
  logic [OW-1:0] owner_q, owner_d, rr_ptr, ptr_d, next_owner, start, win;
  logic [CNT_WIDTH-1:0] rem, rem_d, load;
  logic [3:0] win_fmt;
  logic [6:0] win_len;
  logic found, xfer, tail;
  int idx;
  assign next_owner = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`ifdef WH_ARB_FAST_HANDOFF_EN
  // While locked, arbitration only matters on the tail cycle and must skip the current owner.
  assign start = (state == LOCKED) ? next_owner : rr_ptr;
  assign elig = bus.req & bus.head & ((state == LOCKED) ? ~grant_q : '1);
`else
  assign start = rr_ptr;
  assign elig = bus.req & bus.head;
`endif
  // First eligible index at or after start, wrapping around.
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(start) + k - ((int'(start) + k >= NUM_REQ) ? NUM_REQ : 0);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win = OW'(idx);
      end
    end
  end
  assign win_fmt = bus.hdr_fmt[win];
  assign win_len = bus.hdr_len[win];
  assign load = (win_fmt == FMT_SHORT_READ || win_fmt == FMT_SHORT_WRITE) ? CNT_WIDTH'(win_len[3:0]) + CNT_WIDTH'(1)
              : (win_fmt == FMT_LONG_READ || win_fmt == FMT_LONG_WRITE) ? CNT_WIDTH'(win_len) + CNT_WIDTH'(2)
              : CNT_WIDTH'(win_len) + CNT_WIDTH'(1);
  assign xfer = (state == LOCKED) & bus.req[owner_q] & bus.credit_avail;
  assign tail = xfer & (rem == CNT_WIDTH'(1));
  always_comb begin
    state_d = state;
    grant_d = grant_q;
    owner_d = owner_q;
    rem_d = rem;
    ptr_d = rr_ptr;
    if (state == IDLE) begin
      if (found) begin
        state_d = LOCKED;
        grant_d = NUM_REQ'(1) << win;
        owner_d = win;
        rem_d = load;
      end
    end else begin
      if (xfer) rem_d = rem - CNT_WIDTH'(1);
      if (tail) begin
        state_d = IDLE;
        grant_d = '0;
        ptr_d = next_owner;
`ifdef WH_ARB_FAST_HANDOFF_EN
        if (found) begin
          state_d = LOCKED;
          grant_d = NUM_REQ'(1) << win;
          owner_d = win;
          rem_d = load;
        end
`endif
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rem <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rem <= rem_d;
      rr_ptr <= ptr_d;
    end
  end
  assign bus.grant = grant_q;
  assign bus.owner = owner_q;
  assign bus.xfer = xfer;
  assign bus.tail = tail;
  assign bus.busy = (state == LOCKED);
endmodule

// File: tb/tb_wormhole_arbiter.sv
// tb_wormhole_arbiter: directed table plus hand sequences for the wormhole arbiter
module tb_wormhole_arbiter;
  localparam int N = 5;
  localparam int W = 8;
  localparam logic [3:0] SR = 4'h0;
  localparam logic [3:0] SW = 4'h1;
  localparam logic [3:0] LW = 4'h3;
  typedef struct {
    logic [4:0] req;
    logic [4:0] head;
    logic [3:0] fmt;
    logic [6:0] len;
    logic cr;
    logic [4:0] g;
    logic x;
    logic t;
    logic b;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  wormhole_arbiter_if #(.NUM_REQ(N)) bus ();
  wormhole_arbiter #(.NUM_REQ(N), .CNT_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  function automatic vec_t v(input logic [4:0] r, h, input logic [3:0] f, input logic [6:0] l,
                             input logic c, input logic [4:0] g, input logic x, t, b);
    vec_t e;
    e.req = r; e.head = h; e.fmt = f; e.len = l; e.cr = c;
    e.g = g; e.x = x; e.t = t; e.b = b;
    return e;
  endfunction
  function automatic int oh2i(input logic [4:0] g);
    for (int i = 0; i < N; i++) if (g[i]) return i;
    return 0;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [4:0] r, h, input logic [3:0] f, input logic [6:0] l, input logic c);
    bus.req = r;
    bus.head = h;
    for (int i = 0; i < N; i++) begin
      bus.hdr_fmt[i] = f;
      bus.hdr_len[i] = l;
    end
    bus.credit_avail = c;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [7:0] obs;
    return {bus.grant, bus.xfer, bus.tail, bus.busy};
  endfunction
  // Counts transfers from the current sample point until tail or the bound expires.
  task automatic count_tail(output int n, output bit seen, input int bound);
    n = 0;
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      if (k != 0) begin
        tick;
        #4;
      end
      if (bus.xfer) n++;
      if (bus.tail) seen = 1;
    end
  endtask
  initial begin
    int n;
    bit seen;
`ifdef WH_ARB_FAST_HANDOFF_EN
    tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, 5'b00001, 1, 1, 1));
    tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, 5'b01000, 1, 1, 1));
    tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, 5'b00001, 1, 1, 1));
    tbl.push_back(v(5'b01000, 5'b01000, SR, 0, 1, 5'b01000, 1, 1, 1));
    tbl.push_back(v(5'b00000, 5'b00000, SR, 0, 1, 5'b00000, 0, 0, 0));
`else
    for (int p = 0; p < 4; p++) begin
      tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, 5'b00000, 0, 0, 0));
      tbl.push_back(v(5'b01001, 5'b01001, SR, 0, 1, (p % 2 == 0) ? 5'b00001 : 5'b01000, 1, 1, 1));
    end
`endif
    tbl.push_back(v(5'b11111, 5'b00000, SR, 0, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(v(5'b00000, 5'b00000, SR, 0, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(v(5'b00100, 5'b00100, SW, 3, 1, 5'b00000, 0, 0, 0));
    tbl.push_back(v(5'b00100, 5'b00100, SW, 3, 1, 5'b00100, 1, 0, 1));
    tbl.push_back(v(5'b00100, 5'b00000, SW, 3, 1, 5'b00100, 1, 0, 1));
    tbl.push_back(v(5'b00100, 5'b00000, SW, 3, 1, 5'b00100, 1, 0, 1));
    tbl.push_back(v(5'b00100, 5'b00000, SW, 3, 1, 5'b00100, 1, 1, 1));
    tbl.push_back(v(5'b00000, 5'b00000, SW, 3, 1, 5'b00000, 0, 0, 0));
    rst = 1'b1;
    drive(5'b11111, 5'b11111, SW, 3, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("reset_grant", bus.grant, 0);
    chk("reset_owner", bus.owner, 0);
    chk("reset_xfer", bus.xfer, 0);
    chk("reset_tail", bus.tail, 0);
    chk("reset_busy", bus.busy, 0);
    drive(0, 0, SR, 0, 0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      tick;
      drive(tbl[i].req, tbl[i].head, tbl[i].fmt, tbl[i].len, tbl[i].cr);
      #4;
      chk($sformatf("row%0d", i), obs(), {tbl[i].g, tbl[i].x, tbl[i].t, tbl[i].b});
      if (tbl[i].b) chk($sformatf("row%0d_owner", i), bus.owner, oh2i(tbl[i].g));
    end
    tick;
    drive(5'b00010, 5'b00010, LW, 127, 1);
    #4;
    chk("long_idle", obs(), 0);
    tick;
    #4;
    chk("long_grant", bus.grant, 5'b00010);
    count_tail(n, seen, 300);
    chk("long_xfers", n, 129);
    chk("long_tail_seen", seen, 1);
    tick;
    drive(0, 0, SR, 0, 1);
    #4;
    chk("long_after", obs(), 0);
    tick;
    drive(5'b10000, 5'b10000, SW, 5, 1);
    #4;
    chk("stall_idle", obs(), 0);
    tick;
    #4;
    chk("stall_flit1", obs(), {5'b10000, 3'b101});
    tick;
    drive(5'b10000, 5'b00000, SW, 5, 1);
    #4;
    chk("stall_flit2", obs(), {5'b10000, 3'b101});
    for (int k = 0; k < 5; k++) begin
      tick;
      drive(5'b10001, 5'b10001, SW, 5, 0);
      #4;
      chk($sformatf("stall%0d", k), obs(), {5'b10000, 3'b001});
    end
    tick;
    drive(5'b10000, 5'b00000, SW, 5, 1);
    #4;
    count_tail(n, seen, 20);
    chk("stall_resume_xfers", n, 4);
    chk("stall_resume_tail", seen, 1);
    tick;
    drive(5'b00100, 5'b00100, SR, 0, 1);
    #4;
    tick;
    drive(5'b00100, 5'b00000, SR, 0, 1);
    #4;
    chk("pre_rst_pkt", obs(), {5'b00100, 3'b111});
    tick;
    drive(5'b01000, 5'b01000, SW, 5, 1);
    #4;
    tick;
    drive(5'b01000, 5'b00000, SW, 5, 1);
    #4;
    chk("rst_flit1", obs(), {5'b01000, 3'b101});
    tick;
    #4;
    chk("rst_flit2", obs(), {5'b01000, 3'b101});
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out", {bus.grant, bus.owner, bus.xfer, bus.tail, bus.busy}, 0);
    drive(5'b10100, 5'b10100, SR, 0, 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick;
    #4;
    chk("post_rst_grant", bus.grant, 5'b00100);
    drive(0, 0, SR, 0, 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    tick;
    drive(5'b00110, 5'b00110, SR, 0, 1);
    #4;
    chk("b2b_idle", obs(), 0);
    tick;
    #4;
    chk("b2b_first", obs(), {5'b00010, 3'b111});
    tick;
    #4;
`ifdef WH_ARB_FAST_HANDOFF_EN
    chk("b2b_handoff", obs(), {5'b00100, 3'b111});
`else
    chk("b2b_gap", obs(), 0);
    tick;
    #4;
    chk("b2b_second", obs(), {5'b00100, 3'b111});
`endif
    drive(0, 0, SR, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
